// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter: access-FSM state encoding,
// requester port IDs and the default bus widths.
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_SETUP = 3'd1,
        RD_LATCH = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } acc_state_t;

    typedef logic [1:0] port_id_t;

    localparam port_id_t PORT_NONE = 2'd0;
    localparam port_id_t PORT_IF   = 2'd1;
    localparam port_id_t PORT_DM   = 2'd2;

    // True in the final cycle of an access, where data is captured and ack issued.
    function automatic logic is_last_state(input acc_state_t s);
        return (s == RD_LATCH) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: steps one read (2 cycles) or write (3 cycles) and
// generates the registered active-low SRAM strobes and the data-bus enable.
// Ports:
//   CLK, RST        clock, async active-low reset
//   i_start         start an access this edge (only honoured in IDLE)
//   i_we            direction of the access being started (1 = write)
//   o_idle_c        sequencer is in IDLE
//   o_last_c        sequencer is in the final cycle of an access
//   o_en_n/o_oe_n/o_we_n  SRAM strobes
//   o_drive         controller drives the SRAM data bus
module sram_access_seq
    import sram_arb_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic i_start,
    input  logic i_we,
    output logic o_idle_c,
    output logic o_last_c,
    output logic o_en_n,
    output logic o_oe_n,
    output logic o_we_n,
    output logic o_drive
);

    acc_state_t r_state;
    logic       r_en_n;
    logic       r_oe_n;
    logic       r_we_n;
    logic       r_drive;

    // Access FSM; strobes change on the same edge as the state so read and
    // write strobe windows never overlap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_en_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_drive <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_en_n <= 1'b0;
                        if (i_we) begin
                            r_state <= WR_SETUP;
                            r_we_n  <= 1'b1;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= RD_SETUP;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                RD_SETUP: begin
                    r_state <= RD_LATCH;
                end
                RD_LATCH: begin
                    r_state <= IDLE;
                    r_en_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                end
                WR_SETUP: begin
                    r_state <= WR_PULSE;
                    r_we_n  <= 1'b0;
                end
                WR_PULSE: begin
                    r_state <= WR_HOLD;
                    r_we_n  <= 1'b1;
                end
                WR_HOLD: begin
                    r_state <= IDLE;
                    r_en_n  <= 1'b1;
                    r_drive <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_en_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_drive <= 1'b0;
                end
            endcase
        end
    end

    assign o_idle_c = (r_state == IDLE);
    assign o_last_c = is_last_state(r_state);
    assign o_en_n   = r_en_n;
    assign o_oe_n   = r_oe_n;
    assign o_we_n   = r_we_n;
    assign o_drive  = r_drive;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM: a read-only fetch port
// (if_*) and a read/write data port (dm_*). Holds arbitration, the latched
// request, read-data registers and ack routing; strobe timing lives in
// sram_access_seq.
// Build option: define SRAM_ARB_FAIR_EN for round-robin on simultaneous
// requests; otherwise the data port always wins a tie.
// Ports:
//   CLK, RST                       clock, async active-low reset
//   if_req/if_addr                 fetch read request (level until if_ack)
//   if_ack/if_rdata                fetch done pulse and read data
//   dm_req/dm_we/dm_addr/dm_wdata  data-port request (level until dm_ack)
//   dm_ack/dm_rdata                data-port done pulse and read data
//   if_stall                       fetch request pending, not yet acked
//   sram_en_n/oe_n/we_n/addr/data  SRAM pins
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              if_stall,
    output logic              sram_en_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data
);

    port_id_t          r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_idle;
    logic w_last;
    logic w_start;
    logic w_pick_dm;
    logic w_drive;

    // No grant while an ack is showing: the requester still holds req then.
    assign w_start = w_idle && !r_if_ack && !r_dm_ack && (if_req || dm_req);

`ifdef SRAM_ARB_FAIR_EN
    logic r_last_dm;

    // On a tie, the port that did not win last time goes first.
    assign w_pick_dm = dm_req && (!if_req || !r_last_dm);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_dm <= 1'b0;
        end else if (w_start) begin
            r_last_dm <= w_pick_dm;
        end
    end
`else
    assign w_pick_dm = dm_req;
`endif

    // Request latch, read-data capture and ack routing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_grant    <= PORT_NONE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if (w_start) begin
                r_grant <= w_pick_dm ? PORT_DM : PORT_IF;
                r_addr  <= w_pick_dm ? dm_addr : if_addr;
                // The fetch port is read-only whatever dm_we says.
                r_we    <= w_pick_dm && dm_we;
                if (w_pick_dm) begin
                    r_wdata <= dm_wdata;
                end
            end else if (w_last) begin
                r_grant <= PORT_NONE;
                if (r_grant == PORT_IF) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= sram_data;
                end
                if (r_grant == PORT_DM) begin
                    r_dm_ack <= 1'b1;
                    if (!r_we) begin
                        r_dm_rdata <= sram_data;
                    end
                end
            end
        end
    end

    sram_access_seq u_seq (
        .CLK      (CLK),
        .RST      (RST),
        .i_start  (w_start),
        .i_we     (w_pick_dm && dm_we),
        .o_idle_c (w_idle),
        .o_last_c (w_last),
        .o_en_n   (sram_en_n),
        .o_oe_n   (sram_oe_n),
        .o_we_n   (sram_we_n),
        .o_drive  (w_drive)
    );

    assign sram_addr = r_addr;
    assign sram_data = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_stall  = if_req && !r_if_ack;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: bus-level SRAM device model, transaction-level
// reference (memory contents, grant order, ack cycle numbers), directed cases
// followed by randomized request mixes.
module tb_sram_bus_arbiter;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          if_stall;
    logic          sram_en_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .if_stall  (if_stall),
        .sram_en_n (sram_en_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_addr (sram_addr),
        .sram_data (sram_data)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- SRAM device model ----------------
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    logic [DW-1:0] mdl_q = '0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return DW'(a) ^ 16'h5C3A;
    endfunction

    always @(negedge CLK)
        mdl_q <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : dflt(sram_addr);

    always @(posedge CLK)
        if (RST && !sram_en_n && !sram_we_n) sram_mem[sram_addr] = sram_data;

    assign sram_data = (!sram_en_n && !sram_oe_n) ? mdl_q : 'z;

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            last_dm = 1'b0;
    logic [DW-1:0] held_if = '0;
    logic [DW-1:0] held_dm = '0;
    logic [AW-1:0] exp_wa  = '0;
    logic [DW-1:0] exp_wd  = '0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic bit tie_to_dm();
`ifdef SRAM_ARB_FAIR_EN
        return !last_dm;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- bus monitor ----------------
    int            oe_cnt = 0;
    int            we_cnt = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          p_we   = 1'b1;
    logic          p_en   = 1'b1;
    bit            post_chk = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            post_chk = 1'b0;
        end else begin
            if (!sram_oe_n) begin
                oe_cnt++;
                chk("no_contention", 32'(sram_we_n), 32'(1));
            end
            if (post_chk) begin
                chk("wr_hold_addr", 32'(sram_addr), 32'(exp_wa));
                chk("wr_hold_data", 32'(sram_data), 32'(exp_wd));
                chk("wr_hold_we", 32'(sram_we_n), 32'(1));
                chk("wr_hold_en", 32'(sram_en_n), 32'(0));
                post_chk = 1'b0;
            end
            if (!sram_we_n) begin
                we_cnt++;
                chk("wr_addr", 32'(sram_addr), 32'(exp_wa));
                chk("wr_data", 32'(sram_data), 32'(exp_wd));
                chk("wr_setup_addr", 32'(p_addr), 32'(exp_wa));
                chk("wr_setup_data", 32'(p_data), 32'(exp_wd));
                chk("wr_setup_en", 32'(p_en), 32'(0));
                chk("wr_setup_we", 32'(p_we), 32'(1));
                post_chk = 1'b1;
            end
            p_addr = sram_addr;
            p_data = sram_data;
            p_we   = sram_we_n;
            p_en   = sram_en_n;
        end
    end

    // One or two simultaneous requests; called at a negedge. Grant order and
    // ack cycles come from the arbitration rules: read 2 edges, write 3 edges,
    // loser granted 2 edges after the winner's ack.
    task automatic run_pair(input bit use_if, input bit use_dm, input bit dwe,
                            input logic [AW-1:0] ia, input logic [AW-1:0] da,
                            input logic [DW-1:0] wd, input int scr, input bit drop);
        bit            win_dm;
        int            g, lat_dm, exp_if, exp_dm, ack_w, c_end, oe0, we0, nrd, nwr;
        logic [DW-1:0] exp_if_rd, exp_dm_rd;
        win_dm    = use_dm && (!use_if || tie_to_dm());
        lat_dm    = dwe ? 3 : 2;
        g         = cyc + 1;
        exp_if    = -1;
        exp_dm    = -1;
        exp_if_rd = held_if;
        exp_dm_rd = held_dm;
        if (win_dm) begin
            exp_dm = g + lat_dm;
            if (dwe) begin ref_mem[da] = wd; exp_wa = da; exp_wd = wd; end
            else exp_dm_rd = ref_rd(da);
            if (use_if) begin exp_if = exp_dm + 4; exp_if_rd = ref_rd(ia); end
            last_dm = !use_if;
        end else begin
            exp_if    = g + 2;
            exp_if_rd = ref_rd(ia);
            if (use_dm) begin
                exp_dm = exp_if + 2 + lat_dm;
                if (dwe) begin ref_mem[da] = wd; exp_wa = da; exp_wd = wd; end
                else exp_dm_rd = ref_rd(da);
            end
            last_dm = use_dm;
        end
        nrd   = (use_if ? 1 : 0) + ((use_dm && !dwe) ? 1 : 0);
        nwr   = (use_dm && dwe) ? 1 : 0;
        ack_w = win_dm ? exp_dm : exp_if;
        c_end = ((exp_if > exp_dm) ? exp_if : exp_dm) + 1;
        oe0   = oe_cnt;
        we0   = we_cnt;

        if_req   = use_if;
        if_addr  = ia;
        dm_req   = use_dm;
        dm_we    = use_dm ? dwe : 1'($urandom);
        dm_addr  = da;
        dm_wdata = wd;

        for (int n = 0; n < 40 && cyc < c_end; n++) begin
            @(negedge CLK);
            chk("if_ack", 32'(if_ack), 32'(cyc == exp_if));
            chk("dm_ack", 32'(dm_ack), 32'(cyc == exp_dm));
            chk("if_stall", 32'(if_stall), 32'(if_req && cyc != exp_if));
            if (cyc == exp_if) begin held_if = exp_if_rd; if_req = 1'b0; end
            if (cyc == exp_dm) begin held_dm = exp_dm_rd; dm_req = 1'b0; end
            chk("if_rdata", 32'(if_rdata), 32'(held_if));
            chk("dm_rdata", 32'(dm_rdata), 32'(held_dm));
            // Disturb the winner's inputs after grant; latched values must rule.
            if (cyc >= g && cyc < ack_w) begin
                if (drop && cyc == g) begin
                    if (win_dm) dm_req = 1'b0; else if_req = 1'b0;
                end
                if (scr == 1) begin
                    if (win_dm) begin
                        dm_addr  = AW'($urandom);
                        dm_wdata = DW'($urandom);
                        dm_we    = 1'($urandom);
                    end else begin
                        if_addr = AW'($urandom);
                    end
                end
                if (scr == 2 && win_dm && cyc == g + 1) dm_addr = 18'h3FFFF;
            end
        end
        chk("oe_low_cycles", 32'(oe_cnt - oe0), 32'(2 * nrd));
        chk("we_low_cycles", 32'(we_cnt - we0), 32'(nwr));
    endtask

    // Reset in the middle of WR_PULSE; called at a negedge.
    task automatic abort_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wa   = a;
        exp_wd   = d;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = a;
        dm_wdata = d;
        repeat (2) @(negedge CLK);
        chk("abort_in_pulse", 32'(sram_we_n), 32'(0));
        #2 RST = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'(1));
        chk("abort_en_n", 32'(sram_en_n), 32'(1));
        chk("abort_oe_n", 32'(sram_oe_n), 32'(1));
        chk("abort_addr", 32'(sram_addr), 32'(0));
        chk("abort_ack", 32'(dm_ack), 32'(0));
        dm_req  = 1'b0;
        held_if = '0;
        held_dm = '0;
        last_dm = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            chk("abort_no_ack", 32'(dm_ack), 32'(0));
        end
        chk("abort_if_rdata", 32'(if_rdata), 32'(0));
        chk("abort_dm_rdata", 32'(dm_rdata), 32'(0));
    endtask

    bit            r_use_if, r_use_dm, r_dwe, r_drop;
    int            r_kind, r_scr;
    logic [AW-1:0] r_ia, r_da;
    logic [DW-1:0] r_wd;

    initial begin
        RST      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        #1 RST = 1'b0;
        #2;
        chk("rst_en_n", 32'(sram_en_n), 32'(1));
        chk("rst_oe_n", 32'(sram_oe_n), 32'(1));
        chk("rst_we_n", 32'(sram_we_n), 32'(1));
        chk("rst_addr", 32'(sram_addr), 32'(0));
        chk("rst_if_ack", 32'(if_ack), 32'(0));
        chk("rst_dm_ack", 32'(dm_ack), 32'(0));
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_dm_rdata", 32'(dm_rdata), 32'(0));
        chk("rst_if_stall", 32'(if_stall), 32'(0));
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Fetch read of preloaded word.
        sram_mem[18'h00010] = 16'hA5A5;
        ref_mem[18'h00010]  = 16'hA5A5;
        run_pair(1'b1, 1'b0, 1'b0, 18'h00010, '0, '0, 0, 1'b0);
        chk("if_rdata_a5a5", 32'(if_rdata), 32'h0000A5A5);

        // Data-port write then read-back.
        run_pair(1'b0, 1'b1, 1'b1, '0, 18'h00200, 16'h1234, 0, 1'b0);
        run_pair(1'b0, 1'b1, 1'b0, '0, 18'h00200, '0, 0, 1'b0);
        chk("dm_rdata_1234", 32'(dm_rdata), 32'h00001234);

        // Address changed during WR_PULSE must not redirect the write.
        run_pair(1'b0, 1'b1, 1'b1, '0, 18'h0ABCD, 16'hBEEF, 2, 1'b0);
        run_pair(1'b0, 1'b1, 1'b0, '0, 18'h0ABCD, '0, 0, 1'b0);
        chk("latched_wr_addr", 32'(dm_rdata), 32'h0000BEEF);
        run_pair(1'b0, 1'b1, 1'b0, '0, 18'h3FFFF, '0, 0, 1'b0);

        // Simultaneous requests, repeated ties, tie with write to same word.
        repeat (4) run_pair(1'b1, 1'b1, 1'b0, 18'h00010, 18'h00200, '0, 0, 1'b0);
        run_pair(1'b1, 1'b1, 1'b1, 18'h00200, 18'h00200, 16'h7777, 0, 1'b0);
        run_pair(1'b1, 1'b1, 1'b1, 18'h00200, 18'h00200, 16'h8888, 0, 1'b0);

        // Fetch request with dm_we high and dm idle is still a read.
        dm_we = 1'b1;
        run_pair(1'b1, 1'b0, 1'b1, 18'h00200, '0, 16'hFFFF, 0, 1'b0);

        // Request dropped before ack still completes.
        run_pair(1'b1, 1'b0, 1'b0, 18'h00010, '0, '0, 0, 1'b1);

        abort_write(18'h2AAAA, 16'hDEAD);

        for (int i = 0; i < 80; i++) begin
            r_kind   = int'($urandom_range(0, 2));
            r_use_if = (r_kind != 1);
            r_use_dm = (r_kind != 0);
            r_dwe    = 1'($urandom);
            r_ia     = 18'h01000 + AW'($urandom_range(0, 7));
            r_da     = 18'h01000 + AW'($urandom_range(0, 7));
            r_wd     = DW'($urandom);
            r_scr    = int'($urandom_range(0, 1));
            r_drop   = ($urandom_range(0, 3) == 0);
            run_pair(r_use_if, r_use_dm, r_dwe, r_ia, r_da, r_wd, r_scr, r_drop);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
